// File: rtl/button_io_port.sv
// Memory-mapped push-button port: four buttons are synchronized and debounced.
// Each debounced rising level latches a sticky event bit and bumps a press counter.
// The processor reads LEVEL, EVENT and COUNT words at BASE_ADDR..BASE_ADDR+2.
module button_io_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 400000,
  parameter logic [31:0] BASE_ADDR       = 32'd4098
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        BTNU,
  input  logic        BTNL,
  input  logic        BTND,
  input  logic        BTNR,
  input  logic [31:0] address_dmem,
  input  logic        wren,
  input  logic [31:0] data,
  output logic        io_hit,
  output logic [31:0] q_io,
  output logic        btn_irq
);

  // Count value seen on the edge that completes the debounce window.
  localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic [3:0]  btn_raw;
  logic [3:0]  sync1_reg, sync2_reg;
  logic [3:0]  level_reg, level_next;
  logic [3:0]  rise;
  logic [3:0]  event_reg, event_next, event_clr;
  logic [15:0] count_reg, count_next;
  logic [2:0]  rise_cnt;
  logic        irq_reg;
  logic        sel_level, sel_event, sel_count;
  logic        unused_data;

  // Bit order shared by every register: [0]=U, [1]=L, [2]=D, [3]=R.
  assign btn_raw = {BTNR, BTND, BTNL, BTNU};

  // Two-flop synchronizer on the raw button levels.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_reg <= 4'b0;
      sync2_reg <= 4'b0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_debounce
      logic [19:0] cnt_reg, cnt_next;
      logic        differ, done;

      // Count only while the synchronized input disagrees with the accepted level;
      // any agreement (including a bounce back) restarts the window from zero.
      assign differ         = sync2_reg[gi] ^ level_reg[gi];
      assign done           = differ & (cnt_reg == DB_LAST);
      assign cnt_next       = (differ && !done) ? cnt_reg + 20'd1 : 20'd0;
      assign level_next[gi] = level_reg[gi] ^ done;

      // Per-button debounce counter.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          cnt_reg <= 20'd0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
    end
  endgenerate

  // Address decode for the three-word window.
  assign sel_level = (address_dmem == BASE_ADDR);
  assign sel_event = (address_dmem == BASE_ADDR + 32'd1);
  assign sel_count = (address_dmem == BASE_ADDR + 32'd2);
  assign io_hit    = sel_level | sel_event | sel_count;

  // Only 0->1 transitions of the debounced level count as presses.
  assign rise     = level_next & ~level_reg;
  assign rise_cnt = {2'b0, rise[0]} + {2'b0, rise[1]} + {2'b0, rise[2]} + {2'b0, rise[3]};

  // A press on the same edge as a clear always survives: set is ORed after the clear.
  assign event_clr  = (wren && sel_event) ? data[3:0] : 4'b0;
  assign event_next = (event_reg & ~event_clr) | rise;

  // A store to COUNT restarts the count from whatever presses land on that edge.
  assign count_next = (wren && sel_count) ? {13'b0, rise_cnt}
                                          : count_reg + {13'b0, rise_cnt};

  // Accepted levels, sticky events, press counter and interrupt flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level_reg <= 4'b0;
      event_reg <= 4'b0;
      count_reg <= 16'b0;
      irq_reg   <= 1'b0;
    end else begin
      level_reg <= level_next;
      event_reg <= event_next;
      count_reg <= count_next;
      irq_reg   <= |event_next;
    end
  end

  assign btn_irq = irq_reg;

  // Read mux; words outside the window read as zero.
  always_comb begin
    q_io = 32'b0;
    if (sel_level) begin
      q_io = {28'b0, level_reg};
    end else if (sel_event) begin
      q_io = {28'b0, event_reg};
    end else if (sel_count) begin
      q_io = {16'b0, count_reg};
    end
  end

  // Upper store-data bits have no destination in this block.
  assign unused_data = ^data[31:4];

endmodule

// File: tb/tb_button_io_port.sv
// Bench for button_io_port: a fast-debounce instance for the functional scenarios
// and a minimum-debounce instance used to drive the press counter up to its wrap point.
module tb_button_io_port;

  localparam logic [31:0] LEVEL_A = 32'd4098;
  localparam logic [31:0] EVENT_A = 32'd4099;
  localparam logic [31:0] COUNT_A = 32'd4100;

  logic        clock;
  logic        reset;
  logic        btnu, btnl, btnd, btnr;
  logic [31:0] address_dmem, data;
  logic        wren;
  logic        io_hit, btn_irq;
  logic [31:0] q_io;

  logic [3:0]  b2;
  logic [31:0] address_dmem2, data2;
  logic        wren2;
  logic        io_hit2, btn_irq2;
  logic [31:0] q_io2;

  logic [31:0] got, exp;
  logic [31:0] sb[$];
  int          checks;
  int          failures;

  button_io_port #(.DEBOUNCE_CYCLES(4), .BASE_ADDR(32'd4098)) dut (
    .clock(clock), .reset(reset),
    .BTNU(btnu), .BTNL(btnl), .BTND(btnd), .BTNR(btnr),
    .address_dmem(address_dmem), .wren(wren), .data(data),
    .io_hit(io_hit), .q_io(q_io), .btn_irq(btn_irq)
  );

  button_io_port #(.DEBOUNCE_CYCLES(2), .BASE_ADDR(32'd4098)) dut2 (
    .clock(clock), .reset(reset),
    .BTNU(b2[0]), .BTNL(b2[1]), .BTND(b2[2]), .BTNR(b2[3]),
    .address_dmem(address_dmem2), .wren(wren2), .data(data2),
    .io_hit(io_hit2), .q_io(q_io2), .btn_irq(btn_irq2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges, ending on a falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    address_dmem = a;
    #1;
    v = q_io;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address_dmem = a;
    data = d;
    wren = 1'b1;
    step(1);
    wren = 1'b0;
    data = 32'h0;
  endtask

  task automatic rd2(input logic [31:0] a, output logic [31:0] v);
    address_dmem2 = a;
    #1;
    v = q_io2;
  endtask

  task automatic wr2(input logic [31:0] a, input logic [31:0] d);
    address_dmem2 = a;
    data2 = d;
    wren2 = 1'b1;
    step(1);
    wren2 = 1'b0;
    data2 = 32'h0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    step(2);
    sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0);
    rd(LEVEL_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_level act=0x%0h req=0x%0h", got, exp); end
    rd(EVENT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_event act=0x%0h req=0x%0h", got, exp); end
    rd(COUNT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_count act=0x%0h req=0x%0h", got, exp); end
    got = {31'b0, btn_irq}; exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_irq act=0x%0h req=0x%0h", got, exp); end
    reset = 1'b1;
    step(2);
    // Window boundaries: one word below and one word above are not decoded.
    sb.push_back(32'h1); sb.push_back(32'h0); sb.push_back(32'h0);
    rd(COUNT_A, got); got = {31'b0, io_hit}; exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL hit_top act=0x%0h req=0x%0h", got, exp); end
    rd(32'd4101, got); got = {31'b0, io_hit}; exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL hit_above act=0x%0h req=0x%0h", got, exp); end
    rd(32'd4097, got); got = {31'b0, io_hit}; exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL hit_below act=0x%0h req=0x%0h", got, exp); end
  endtask

  task automatic test_clean_press;
    btnl = 1'b1;
    sb.push_back(32'h0); sb.push_back(32'h2); sb.push_back(32'h2); sb.push_back(32'h1);
    step(5);
    rd(LEVEL_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL clean_level_edge5 act=0x%0h req=0x%0h", got, exp); end
    step(1);
    rd(LEVEL_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL clean_level_edge6 act=0x%0h req=0x%0h", got, exp); end
    rd(EVENT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL clean_event act=0x%0h req=0x%0h", got, exp); end
    rd(COUNT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL clean_count act=0x%0h req=0x%0h", got, exp); end
    step(1);
    sb.push_back(32'h1);
    got = {31'b0, btn_irq}; exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL clean_irq act=0x%0h req=0x%0h", got, exp); end
    // Release: level falls, event stays latched, count does not move.
    btnl = 1'b0;
    sb.push_back(32'h0); sb.push_back(32'h2); sb.push_back(32'h1);
    step(8);
    rd(LEVEL_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL release_level act=0x%0h req=0x%0h", got, exp); end
    rd(EVENT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL release_event act=0x%0h req=0x%0h", got, exp); end
    rd(COUNT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL release_count act=0x%0h req=0x%0h", got, exp); end
    wr(EVENT_A, 32'h2);
    wr(COUNT_A, 32'h0);
  endtask

  task automatic test_bounce;
    btnu = 1'b1; step(3);
    btnu = 1'b0; step(1);
    btnu = 1'b1;
    sb.push_back(32'h0); sb.push_back(32'h1); sb.push_back(32'h1); sb.push_back(32'h1);
    step(5);
    rd(LEVEL_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL bounce_level_early act=0x%0h req=0x%0h", got, exp); end
    step(1);
    rd(LEVEL_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL bounce_level act=0x%0h req=0x%0h", got, exp); end
    rd(EVENT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL bounce_event act=0x%0h req=0x%0h", got, exp); end
    step(2);
    rd(COUNT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL bounce_count act=0x%0h req=0x%0h", got, exp); end
  endtask

  task automatic test_w1c;
    btnl = 1'b1; btnd = 1'b1; btnr = 1'b1;
    sb.push_back(32'hF); sb.push_back(32'h4);
    step(6);
    rd(EVENT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL w1c_event_all act=0x%0h req=0x%0h", got, exp); end
    rd(COUNT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL w1c_count act=0x%0h req=0x%0h", got, exp); end
    wr(EVENT_A, 32'h5);
    sb.push_back(32'hA); sb.push_back(32'h1);
    rd(EVENT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL w1c_event_5 act=0x%0h req=0x%0h", got, exp); end
    step(1);
    got = {31'b0, btn_irq}; exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL w1c_irq_partial act=0x%0h req=0x%0h", got, exp); end
    wr(EVENT_A, 32'hA);
    step(1);
    sb.push_back(32'h0); sb.push_back(32'h0);
    rd(EVENT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL w1c_event_a act=0x%0h req=0x%0h", got, exp); end
    got = {31'b0, btn_irq}; exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL w1c_irq_clear act=0x%0h req=0x%0h", got, exp); end
    // LEVEL is read-only; stores beside the window must not touch anything.
    wr(LEVEL_A, 32'h0);
    wr(32'd4101, 32'hFFFF_FFFF);
    wr(32'd4097, 32'hFFFF_FFFF);
    sb.push_back(32'hF); sb.push_back(32'h0); sb.push_back(32'h4);
    rd(LEVEL_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL ro_level act=0x%0h req=0x%0h", got, exp); end
    rd(EVENT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL outside_event act=0x%0h req=0x%0h", got, exp); end
    rd(COUNT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL outside_count act=0x%0h req=0x%0h", got, exp); end
  endtask

  task automatic test_collision;
    btnu = 1'b0; btnl = 1'b0; btnd = 1'b0; btnr = 1'b0;
    step(8);
    wr(COUNT_A, 32'h0);
    // BTNR level rises on the 6th edge; the W1C store lands on that same edge.
    btnr = 1'b1;
    step(5);
    wr(EVENT_A, 32'h8);
    sb.push_back(32'h8); sb.push_back(32'h1);
    rd(EVENT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL collide_event act=0x%0h req=0x%0h", got, exp); end
    rd(COUNT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL collide_count act=0x%0h req=0x%0h", got, exp); end
    // A COUNT store coinciding with a press loads that press.
    btnr = 1'b0;
    step(8);
    btnr = 1'b1;
    step(5);
    wr(COUNT_A, 32'h0);
    sb.push_back(32'h1);
    rd(COUNT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL clear_collide_count act=0x%0h req=0x%0h", got, exp); end
  endtask

  task automatic test_reset_mid;
    btnr = 1'b0;
    step(8);
    wr(EVENT_A, 32'hF);
    btnu = 1'b1; btnl = 1'b1;
    sb.push_back(32'h3);
    step(6);
    rd(EVENT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL mid_event_pre act=0x%0h req=0x%0h", got, exp); end
    btnd = 1'b1;
    sb.push_back(32'h3);
    step(4);
    rd(LEVEL_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL mid_level_pre act=0x%0h req=0x%0h", got, exp); end
    step(1);
    // BTND counter now at 3; reset lands between clock edges.
    reset = 1'b0; btnu = 1'b0; btnl = 1'b0;
    sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0);
    rd(LEVEL_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL mid_level_rst act=0x%0h req=0x%0h", got, exp); end
    rd(EVENT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL mid_event_rst act=0x%0h req=0x%0h", got, exp); end
    rd(COUNT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL mid_count_rst act=0x%0h req=0x%0h", got, exp); end
    got = {31'b0, btn_irq}; exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL mid_irq_rst act=0x%0h req=0x%0h", got, exp); end
    step(2);
    reset = 1'b1;
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h4); sb.push_back(32'h1);
    step(5);
    rd(LEVEL_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL mid_level_edge5 act=0x%0h req=0x%0h", got, exp); end
    step(1);
    rd(LEVEL_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL mid_level_edge6 act=0x%0h req=0x%0h", got, exp); end
    rd(EVENT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL mid_event_post act=0x%0h req=0x%0h", got, exp); end
    rd(COUNT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL mid_count_post act=0x%0h req=0x%0h", got, exp); end
    btnd = 1'b0;
  endtask

  task automatic test_wrap;
    logic [15:0] model;
    model = 16'h0;
    // Minimum debounce of 2 lets a 4-edge square wave produce one press per period.
    for (int i = 0; i < 16383; i++) begin
      b2 = 4'hF; step(2);
      b2 = 4'h0; step(2);
      model = model + 16'd4;
    end
    step(6);
    sb.push_back({16'b0, model});
    rd2(COUNT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL wrap_bulk_count act=0x%0h req=0x%0h", got, exp); end
    b2 = 4'b0111; step(6);
    model = model + 16'd3;
    sb.push_back({16'b0, model});
    rd2(COUNT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL wrap_ffff act=0x%0h req=0x%0h", got, exp); end
    b2 = 4'b0000; step(6);
    b2 = 4'b0011; step(6);
    model = model + 16'd2;
    sb.push_back({16'b0, model}); sb.push_back(32'h3);
    rd2(COUNT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL wrap_count act=0x%0h req=0x%0h", got, exp); end
    rd2(LEVEL_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL wrap_level act=0x%0h req=0x%0h", got, exp); end
    wr2(COUNT_A, 32'h1234);
    sb.push_back(32'h0); sb.push_back(32'h1);
    rd2(COUNT_A, got); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL wrap_clear act=0x%0h req=0x%0h", got, exp); end
    got = {31'b0, btn_irq2}; exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL wrap_irq act=0x%0h req=0x%0h", got, exp); end
    rd2(32'd4101, got); got = {31'b0, io_hit2} | got; sb.push_back(32'h0); exp = sb.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL wrap_outside act=0x%0h req=0x%0h", got, exp); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    btnu = 1'b0; btnl = 1'b0; btnd = 1'b0; btnr = 1'b0;
    address_dmem = 32'h0; data = 32'h0; wren = 1'b0;
    b2 = 4'h0;
    address_dmem2 = 32'h0; data2 = 32'h0; wren2 = 1'b0;

    test_reset;
    test_clean_press;
    test_bounce;
    test_w1c;
    test_collision;
    test_reset_mid;
    test_wrap;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_io_port.md
BUTTON_IO_PORT -- requirements
Module: button_io_port

Interface
REQ-001 The block SHALL take parameter DEBOUNCE_CYCLES, default 400000, the number of stable cycles required to accept a button level change (10 ms at 40 MHz); legal range 2..2^20-1.
REQ-002 The block SHALL take parameter BASE_ADDR, default 32'd4098, the first of three word addresses this block answers on the data-memory bus.
REQ-003 clock  input  1  single system clock (40 MHz domain); all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 BTNU, BTNL, BTND, BTNR  input  1 each  raw asynchronous push-button levels, 1 = pressed.
REQ-006 address_dmem  input  32  processor data address.
REQ-007 wren  input  1  processor store strobe, one cycle per store.
REQ-008 data  input  32  processor store data.
REQ-009 io_hit  output  1  1 when address_dmem is BASE_ADDR, BASE_ADDR+1 or BASE_ADDR+2 (combinational).
REQ-010 q_io  output  32  read data for the addressed register (combinational from registered state); 0 when io_hit=0.
REQ-011 btn_irq  output  1  registered; 1 while any event bit is set.

Function
REQ-012 Button bit order SHALL be [0]=BTNU, [1]=BTNL, [2]=BTND, [3]=BTNR in every register.
REQ-013 Each button SHALL pass through a two-flop synchronizer before any other logic.
REQ-014 Each button SHALL have its own debounce counter (20 bits) and debounced level bit.
REQ-015 While the synchronized input equals the debounced level, the counter SHALL be held at 0.
REQ-016 While they differ, the counter SHALL increment each cycle; on the cycle it would reach DEBOUNCE_CYCLES, the level SHALL toggle and the counter SHALL return to 0.
REQ-017 A bounce (input returns to the level value) before the count completes SHALL reset the counter to 0 with no level change.
REQ-018 A clean input change SHALL appear on the level bit exactly 2+DEBOUNCE_CYCLES rising edges after the first edge that samples it.
REQ-019 A 0->1 transition of a debounced level SHALL set the matching sticky event bit on the same edge.
REQ-020 A 1->0 transition SHALL NOT affect the event bits.
REQ-021 Register BASE_ADDR (LEVEL), read-only: {28'b0, level[3:0]}; writes ignored.
REQ-022 Register BASE_ADDR+1 (EVENT), write-1-to-clear: a store with wren=1 clears every event bit whose data bit [3:0] is 1; reads return {28'b0, event[3:0]}.
REQ-023 If a set and a W1C of the same event bit coincide on one edge, the set SHALL win (bit remains 1).
REQ-024 Register BASE_ADDR+2 (COUNT): {16'b0, press_count[15:0]}.
REQ-025 press_count SHALL add the number of 0->1 level transitions occurring on that edge (0..4).
REQ-026 press_count SHALL wrap modulo 2^16.
REQ-027 Any store to COUNT SHALL clear press_count to 0, except that presses on the same edge SHALL be loaded as the new value instead of being lost.
REQ-028 Reads SHALL have no side effects.
REQ-029 btn_irq SHALL equal the OR of the event bits as they stand after each edge.
REQ-030 Stores to addresses outside the three-word window SHALL change nothing.

Reset
REQ-031 While reset=0: synchronizer flops, debounce counters, levels, event bits, press_count and btn_irq SHALL be 0.
REQ-032 Combinational outputs SHALL then read 0 for LEVEL, EVENT and COUNT.
REQ-033 An assertion of reset mid-debounce SHALL abandon the count.
REQ-034 After deassertion, a button still held SHALL be treated as a new press: full debounce, then an event and a count.

Verification (DEBOUNCE_CYCLES=4, BASE_ADDR=4098)
REQ-035 Clean press: BTNL 0->1 held -> LEVEL=0x2 exactly 6 edges later; EVENT=0x2; COUNT=1; btn_irq=1 one edge after the event is set.
REQ-036 Bounce: BTNU high 3 cycles, low 1 cycle, then high 4 cycles -> no level change until 6 edges after the final rise; COUNT=1, not 2.
REQ-037 W1C: EVENT=0xF, store 0x5 to 4099 -> EVENT=0xA, btn_irq=1. Then store 0xA -> EVENT=0, btn_irq=0. A store to 4098 leaves LEVEL unchanged.
REQ-038 Set/clear collision: store 0x8 to 4099 on the same edge BTNR's level rises -> EVENT[3]=1, COUNT incremented.
REQ-039 Count wrap and clear: COUNT=0xFFFF plus two simultaneous presses -> 0x0001. A store to 4100 with no coincident press -> 0.
REQ-040 Reset mid-operation: assert reset with counters at 3 and EVENT=0x3 -> all registers 0 immediately. Release with BTND held -> LEVEL=0x4 and EVENT=0x4 after 6 edges.
